// File: rtl/game_pkg.sv
// Shared codes for the N x N game engine: cell/result encodings, FSM states,
// display modes and seven-segment glyphs (gfedcba, active high).
package game_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] RES_PLAY   = 2'b00;
    localparam logic [1:0] RES_X      = 2'b01;
    localparam logic [1:0] RES_O      = 2'b10;
    localparam logic [1:0] RES_DRAW   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_KEY = 2'd1,
        ST_CHECK    = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DISP_DASH = 2'd0,
        DISP_TURN = 2'd1,
        DISP_DRAW = 2'd2,
        DISP_WIN  = 2'd3
    } disp_e;

    localparam logic [1:0] DIR_ROW  = 2'd0;
    localparam logic [1:0] DIR_COL  = 2'd1;
    localparam logic [1:0] DIR_DIAG = 2'd2;
    localparam logic [1:0] DIR_ANTI = 2'd3;

    localparam logic [6:0] GLYPH_P    = 7'h73;
    localparam logic [6:0] GLYPH_1    = 7'h06;
    localparam logic [6:0] GLYPH_2    = 7'h5B;
    localparam logic [6:0] GLYPH_D    = 7'h5E;
    localparam logic [6:0] GLYPH_R    = 7'h50;
    localparam logic [6:0] GLYPH_DASH = 7'h40;

    localparam logic [7:0] COM_DIG0 = 8'b0111_1111;
    localparam logic [7:0] COM_DIG1 = 8'b1011_1111;
    localparam logic [7:0] COM_OFF  = 8'hFF;

endpackage

// File: rtl/game_engine_nxn_if.sv
// Display request from the game FSM to the segment scanner: what to show and
// which player it concerns.
interface game_engine_nxn_if;
    import game_pkg::*;

    disp_e mode;
    logic  player;

    modport master (output mode, output player);
    modport slave  (input  mode, input  player);

endinterface

// File: rtl/seg_scan.sv
// Two-digit seven-segment multiplexer with a slow blink used for the win banner.
module seg_scan
    import game_pkg::*;
#(
    parameter int DIV = 25000
) (
    input  logic             clk,
    input  logic             rst_n,
    game_engine_nxn_if.slave disp,
    output logic [6:0]       seg_txt,
    output logic [7:0]       seg_com
);
    localparam int SCAN_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              digit_q, digit_d;
    logic [8:0]        blink_q, blink_d;
    logic [6:0]        txt_q, txt_d;
    logic [7:0]        com_q, com_d;
    logic [6:0]        glyph0, glyph1;
    logic              wrap, blank;

    assign wrap = (scan_q == SCAN_W'(DIV - 1));

    always_comb begin
        scan_d  = wrap ? '0 : scan_q + SCAN_W'(1);
        digit_d = wrap ? ~digit_q : digit_q;
        blink_d = wrap ? blink_q + 9'd1 : blink_q;
        glyph0  = GLYPH_DASH;
        glyph1  = GLYPH_DASH;
        case (disp.mode)
            DISP_TURN, DISP_WIN: begin
                glyph0 = GLYPH_P;
                glyph1 = disp.player ? GLYPH_2 : GLYPH_1;
            end
            DISP_DRAW: begin
                glyph0 = GLYPH_D;
                glyph1 = GLYPH_R;
            end
            default: ;
        endcase
        // One blink period is 512 digit slots; the upper 256 are dark.
        blank = (disp.mode == DISP_WIN) && blink_q[8];
        txt_d = digit_q ? glyph1 : glyph0;
        com_d = blank ? COM_OFF : (digit_q ? COM_DIG1 : COM_DIG0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q  <= '0;
            digit_q <= 1'b0;
            blink_q <= '0;
            txt_q   <= '0;
            com_q   <= COM_OFF;
        end else begin
            scan_q  <= scan_d;
            digit_q <= digit_d;
            blink_q <= blink_d;
            txt_q   <= txt_d;
            com_q   <= com_d;
        end
    end

    assign seg_txt = txt_q;
    assign seg_com = com_q;

endmodule

// File: rtl/game_engine_nxn.sv
// N x N K-in-a-row game engine: move validation, four-cycle line check through
// the placed cell, draw detection and a two-digit status display.
module game_engine_nxn
    import game_pkg::*;
#(
    parameter int N   = 3,
    parameter int K   = 3,
    parameter int DIV = 25000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   key_valid,
    input  logic [$clog2(N*N)-1:0] key_idx,
    output logic [2*N*N-1:0]       board_o,
    output logic                   turn_o,
    output logic [1:0]             result_o,
    output logic                   move_ack,
    output logic                   move_err,
    output logic                   busy,
    output logic [6:0]             seg_txt,
    output logic [7:0]             seg_com
);
    localparam int CELLS = N * N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int CNT_W = $clog2(CELLS + 1);

    state_e           state_q, state_d;
    logic [1:0]       cells_q [CELLS];
    logic [1:0]       cells_d [CELLS];
    logic             turn_q, turn_d;
    logic [1:0]       result_q, result_d;
    logic [CNT_W-1:0] moves_q, moves_d;
    logic [1:0]       dir_q, dir_d;
    logic             win_q, win_d;
    logic [2:0]       row_q, row_d, col_q, col_d;
    logic             ack_q, ack_d, err_q, err_d;

    logic             key_ok;
    logic [1:0]       mark;
    int               dr, dc, rr, cc, line_cnt;
    logic             run;
    logic             line_win;

    assign key_ok = (int'(key_idx) < CELLS) && (cells_q[key_idx] == CELL_EMPTY);
    assign mark   = turn_q ? CELL_O : CELL_X;

    // Walk outward from the placed cell along the selected direction, both senses.
    always_comb begin
        dr       = (dir_q == DIR_ROW) ? 0 : 1;
        dc       = (dir_q == DIR_COL) ? 0 : ((dir_q == DIR_ANTI) ? -1 : 1);
        rr       = 0;
        cc       = 0;
        run      = 1'b0;
        line_cnt = 1;
        for (int sense = 0; sense < 2; sense++) begin
            run = 1'b1;
            for (int s = 1; s < N; s++) begin
                rr = int'(row_q) + ((sense == 0) ? s : -s) * dr;
                cc = int'(col_q) + ((sense == 0) ? s : -s) * dc;
                if (run && rr >= 0 && rr < N && cc >= 0 && cc < N
                    && cells_q[IDX_W'(rr * N + cc)] == mark) begin
                    line_cnt = line_cnt + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        line_win = (line_cnt >= K);
    end

    always_comb begin
        state_d  = state_q;
        cells_d  = cells_q;
        turn_d   = turn_q;
        result_d = result_q;
        moves_d  = moves_q;
        dir_d    = dir_q;
        win_d    = win_q;
        row_d    = row_q;
        col_d    = col_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        if (start) begin
            state_d  = ST_WAIT_KEY;
            cells_d  = '{default: CELL_EMPTY};
            turn_d   = 1'b0;
            result_d = RES_PLAY;
            moves_d  = '0;
            dir_d    = DIR_ROW;
            win_d    = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_KEY: begin
                    if (key_valid) begin
                        if (key_ok) begin
                            cells_d[key_idx] = mark;
                            moves_d          = moves_q + CNT_W'(1);
                            row_d            = 3'(int'(key_idx) / N);
                            col_d            = 3'(int'(key_idx) % N);
                            dir_d            = DIR_ROW;
                            win_d            = 1'b0;
                            ack_d            = 1'b1;
                            state_d          = ST_CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    win_d = win_q | line_win;
                    dir_d = dir_q + 2'd1;
                    if (dir_q == DIR_ANTI) begin
                        if (win_d) begin
                            result_d = turn_q ? RES_O : RES_X;
                            state_d  = ST_DONE;
                        end else if (moves_q == CNT_W'(CELLS)) begin
                            result_d = RES_DRAW;
                            state_d  = ST_DONE;
                        end else begin
                            turn_d  = ~turn_q;
                            state_d = ST_WAIT_KEY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cells_q  <= '{default: CELL_EMPTY};
            turn_q   <= 1'b0;
            result_q <= RES_PLAY;
            moves_q  <= '0;
            dir_q    <= DIR_ROW;
            win_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            turn_q   <= turn_d;
            result_q <= result_d;
            moves_q  <= moves_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            row_q    <= row_d;
            col_q    <= col_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_pack
        assign board_o[2*gi +: 2] = cells_q[gi];
    end

    assign turn_o   = turn_q;
    assign result_o = result_q;
    assign move_ack = ack_q;
    assign move_err = err_q;
    assign busy     = (state_q == ST_CHECK);

    game_engine_nxn_if disp_if ();

    always_comb begin
        disp_if.mode   = DISP_DASH;
        disp_if.player = turn_q;
        case (state_q)
            ST_WAIT_KEY, ST_CHECK: disp_if.mode = DISP_TURN;
            ST_DONE: begin
                disp_if.mode   = (result_q == RES_DRAW) ? DISP_DRAW : DISP_WIN;
                disp_if.player = (result_q == RES_O);
            end
            default: ;
        endcase
    end

    seg_scan #(.DIV(DIV)) u_seg_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp    (disp_if),
        .seg_txt (seg_txt),
        .seg_com (seg_com)
    );

endmodule

// File: tb/tb_game_engine_nxn.sv
// Scoreboard bench for game_engine_nxn: a 3x3 and a 4x4 (K=3) instance driven
// with directed move sequences; monitors pop expected events on ack/err/eval-end.
module tb_game_engine_nxn;

    localparam int DIV = 4;
    localparam int EV_ACK  = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int          ev;
        logic [31:0] board;
        logic        turn;
        logic [1:0]  result;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst3_n, rst4_n, start3, start4, kv3, kv4;
    logic [3:0]  ki3, ki4;
    logic [17:0] board3;
    logic [31:0] board4;
    logic        turn3, turn4, ack3, ack4, err3, err4, busy3, busy4;
    logic [1:0]  res3, res4;
    logic [6:0]  seg_txt3, seg_txt4;
    logic [7:0]  seg_com3, seg_com4;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ack3_cyc = 0;
    int          ack4_cyc = 0;
    logic        busy3_prev = 1'b0;
    logic        busy4_prev = 1'b0;
    exp_t        q3[$];
    exp_t        q4[$];
    exp_t        e3, e4;
    logic [31:0] mb [2];
    logic        mturn [2];
    logic [1:0]  mres [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    game_engine_nxn #(.N(3), .K(3), .DIV(DIV)) dut3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .key_valid(kv3), .key_idx(ki3),
        .board_o(board3), .turn_o(turn3), .result_o(res3), .move_ack(ack3),
        .move_err(err3), .busy(busy3), .seg_txt(seg_txt3), .seg_com(seg_com3)
    );

    game_engine_nxn #(.N(4), .K(3), .DIV(DIV)) dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .key_valid(kv4), .key_idx(ki4),
        .board_o(board4), .turn_o(turn4), .result_o(res4), .move_ack(ack4),
        .move_err(err4), .busy(busy4), .seg_txt(seg_txt4), .seg_com(seg_com4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 3x3 instance.
    always @(negedge clk) begin
        if (!rst3_n) begin
            busy3_prev <= 1'b0;
        end else begin
            if (ack3 || err3) begin
                if (q3.size() == 0) begin
                    chk("dut3_unexpected_strobe", {30'b0, ack3, err3}, 32'd0);
                end else begin
                    e3 = q3.pop_front();
                    chk("dut3_event_kind", ack3 ? EV_ACK : EV_ERR, e3.ev);
                    chk("dut3_event_board", 32'(board3), e3.board);
                    chk("dut3_event_turn", turn3, e3.turn);
                    chk("dut3_event_result", res3, e3.result);
                    if (ack3) begin
                        chk("dut3_busy_at_ack", busy3, 1);
                        ack3_cyc <= cyc;
                    end
                end
            end
            if (busy3_prev && !busy3) begin
                if (q3.size() == 0) begin
                    chk("dut3_unexpected_eval_end", {31'b0, busy3_prev}, 32'd0);
                end else begin
                    e3 = q3.pop_front();
                    chk("dut3_eval_kind", EV_DONE, e3.ev);
                    chk("dut3_eval_latency", cyc - ack3_cyc, 4);
                    chk("dut3_eval_result", res3, e3.result);
                    chk("dut3_eval_turn", turn3, e3.turn);
                    chk("dut3_eval_board", 32'(board3), e3.board);
                end
            end
            busy3_prev <= busy3;
        end
    end

    // Monitor for the 4x4 instance.
    always @(negedge clk) begin
        if (!rst4_n) begin
            busy4_prev <= 1'b0;
        end else begin
            if (ack4 || err4) begin
                if (q4.size() == 0) begin
                    chk("dut4_unexpected_strobe", {30'b0, ack4, err4}, 32'd0);
                end else begin
                    e4 = q4.pop_front();
                    chk("dut4_event_kind", ack4 ? EV_ACK : EV_ERR, e4.ev);
                    chk("dut4_event_board", board4, e4.board);
                    chk("dut4_event_turn", turn4, e4.turn);
                    chk("dut4_event_result", res4, e4.result);
                    if (ack4) begin
                        chk("dut4_busy_at_ack", busy4, 1);
                        ack4_cyc <= cyc;
                    end
                end
            end
            if (busy4_prev && !busy4) begin
                if (q4.size() == 0) begin
                    chk("dut4_unexpected_eval_end", {31'b0, busy4_prev}, 32'd0);
                end else begin
                    e4 = q4.pop_front();
                    chk("dut4_eval_kind", EV_DONE, e4.ev);
                    chk("dut4_eval_latency", cyc - ack4_cyc, 4);
                    chk("dut4_eval_result", res4, e4.result);
                    chk("dut4_eval_turn", turn4, e4.turn);
                    chk("dut4_eval_board", board4, e4.board);
                end
            end
            busy4_prev <= busy4;
        end
    end

    task automatic push(input int d, input int ev);
        exp_t e;
        e.ev     = ev;
        e.board  = mb[d];
        e.turn   = mturn[d];
        e.result = mres[d];
        if (d == 0) q3.push_back(e);
        else        q4.push_back(e);
    endtask

    // mode 0: accepted, 1: rejected, 2: ignored (no event at all)
    task automatic do_move(input int d, input int idx, input logic [1:0] res_after, input int mode);
        @(posedge clk); #1;
        if (d == 0) begin kv3 = 1'b1; ki3 = 4'(idx); end
        else        begin kv4 = 1'b1; ki4 = 4'(idx); end
        if (mode == 0) begin
            mb[d][2*idx +: 2] = mturn[d] ? 2'b10 : 2'b01;
            push(d, EV_ACK);
            mres[d] = res_after;
            if (res_after == 2'b00) mturn[d] = ~mturn[d];
            push(d, EV_DONE);
        end else if (mode == 1) begin
            push(d, EV_ERR);
        end
        @(posedge clk); #1;
        kv3 = 1'b0;
        kv4 = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic play(input int d, input int ks[9], input int n, input logic [1:0] fin);
        for (int i = 0; i < n; i++) do_move(d, ks[i], (i == n - 1) ? fin : 2'b00, 0);
    endtask

    task automatic start_game(input int d);
        @(posedge clk); #1;
        if (d == 0) start3 = 1'b1;
        else        start4 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        start4 = 1'b0;
        mb[d] = '0;
        mturn[d] = 1'b0;
        mres[d] = 2'b00;
    endtask

    task automatic wait_digit(input string name, input logic [7:0] com, input logic [6:0] txt, input int limit);
        int n = 0;
        @(negedge clk);
        while (seg_com3 !== com && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk({name, "_timeout"}, seg_com3, com);
        else            chk(name, seg_txt3, txt);
    endtask

    task automatic count_dark(input string name, input int span, input int exp_dark);
        int dark = 0;
        for (int i = 0; i < span; i++) begin
            @(negedge clk);
            if (seg_com3 === 8'hFF) dark++;
        end
        chk(name, dark, exp_dark);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d tests", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst3_n = 1'b0; rst4_n = 1'b0; start3 = 1'b0; start4 = 1'b0;
        kv3 = 1'b0; kv4 = 1'b0; ki3 = '0; ki4 = '0;
        for (int d = 0; d < 2; d++) begin
            mb[d] = '0; mturn[d] = 1'b0; mres[d] = 2'b00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_seg_com", seg_com3, 8'hFF);
        chk("reset_seg_txt", seg_txt3, 7'h00);
        chk("reset_board", 32'(board3), 32'd0);
        chk("reset_turn", turn3, 0);
        chk("reset_result", res3, 2'b00);
        chk("reset_strobes", {busy3, ack3, err3}, 3'b000);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        rst4_n = 1'b1;

        wait_digit("idle_dash", 8'h7F, 7'h40, 4 * DIV);

        // Start: fresh game, "P1" on the display
        start_game(0);
        @(negedge clk);
        chk("start_board", 32'(board3), 32'd0);
        chk("start_turn", turn3, 0);
        chk("start_result", res3, 2'b00);
        wait_digit("turn_p1_digit0", 8'h7F, 7'h73, 4 * DIV);
        wait_digit("turn_p1_digit1", 8'hBF, 7'h06, 4 * DIV);

        // X wins on the top row, later keys ignored in DONE
        play(0, '{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5, 2'b01);
        do_move(0, 8, 2'b00, 2);
        @(negedge clk);
        chk("done_board_hold", 32'(board3), mb[0]);
        chk("done_result_hold", res3, 2'b01);
        chk("done_not_busy", busy3, 0);
        wait_digit("win_p1_digit0", 8'h7F, 7'h73, 600 * DIV);
        wait_digit("win_p1_digit1", 8'hBF, 7'h06, 600 * DIV);
        count_dark("win_blink_dark_cycles", 512 * DIV, 256 * DIV);

        // Occupied and out-of-range cells are rejected
        start_game(0);
        do_move(0, 4, 2'b00, 0);
        do_move(0, 4, 2'b00, 1);
        @(negedge clk);
        chk("reject_turn_stays_o", turn3, 1);
        do_move(0, 9, 2'b00, 1);
        wait_digit("turn_p2_digit1", 8'hBF, 7'h5B, 4 * DIV);

        // start wins over a simultaneous key
        @(posedge clk); #1;
        start3 = 1'b1; kv3 = 1'b1; ki3 = 4'd0;
        @(posedge clk); #1;
        start3 = 1'b0; kv3 = 1'b0;
        mb[0] = '0; mturn[0] = 1'b0; mres[0] = 2'b00;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("start_priority_board", 32'(board3), 32'd0);
        chk("start_priority_turn", turn3, 0);

        // Full board, no line: draw shown steadily as "dr"
        play(0, '{0, 1, 2, 4, 3, 5, 7, 6, 8}, 9, 2'b11);
        wait_digit("draw_digit0", 8'h7F, 7'h5E, 4 * DIV);
        wait_digit("draw_digit1", 8'hBF, 7'h50, 4 * DIV);
        count_dark("draw_no_blink", 64, 0);

        // Win on the ninth move beats the draw
        start_game(0);
        play(0, '{0, 1, 2, 4, 3, 5, 7, 8, 6}, 9, 2'b01);
        @(negedge clk);
        chk("last_move_win_result", res3, 2'b01);

        // 4x4, K=3: diagonal 1-6-11
        start_game(1);
        play(1, '{1, 0, 6, 4, 11, 0, 0, 0, 0}, 5, 2'b01);
        @(negedge clk);
        chk("n4_diag_result", res4, 2'b01);

        // Reset two cycles into CHECK discards the evaluation
        start_game(1);
        @(posedge clk); #1;
        kv4 = 1'b1; ki4 = 4'd5;
        mb[1][11:10] = 2'b01;
        push(1, EV_ACK);
        @(posedge clk); #1;
        kv4 = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b1;
        mb[1] = '0; mturn[1] = 1'b0; mres[1] = 2'b00;
        @(negedge clk);
        chk("rst_check_busy", busy4, 0);
        chk("rst_check_board", board4, 32'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst_check_result", res4, 2'b00);
        chk("rst_check_turn", turn4, 0);
        do_move(1, 5, 2'b00, 2);
        @(negedge clk);
        chk("idle_key_ignored_board", board4, 32'd0);

        repeat (4) @(posedge clk);
        chk("dut3_queue_drained", q3.size(), 0);
        chk("dut4_queue_drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_engine_nxn.md
GAME_ENGINE_NXN -- requirements
Module: game_engine_nxn

Interface
REQ-001 SHALL have parameter N, default 3: board side length (3..8).
REQ-002 SHALL have parameter K, default 3: marks in a row needed to win (3..N).
REQ-003 SHALL have parameter DIV, default 25000: display scan divider, in clk cycles per digit.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: new-game pulse from the main menu.
REQ-007 SHALL have port key_valid, input, 1 bit: one-cycle move strobe.
REQ-008 SHALL have port key_idx, input, $clog2(N*N) bits: target cell, row-major, 0..N*N-1.
REQ-009 SHALL have port board_o, output, 2*N*N bits: cell i is held in bits [2i+1:2i], coded 00 empty, 01 X, 10 O.
REQ-010 SHALL have port turn_o, output, 1 bit: 0 means X (P1) is to move, 1 means O (P2) is to move.
REQ-011 SHALL have port result_o, output, 2 bits: 00 playing, 01 X win, 10 O win, 11 draw.
REQ-012 SHALL have port move_ack, output, 1 bit: one-cycle pulse when a move is accepted.
REQ-013 SHALL have port move_err, output, 1 bit: one-cycle pulse when a move is rejected.
REQ-014 SHALL have port busy, output, 1 bit: high while a move is being evaluated.
REQ-015 SHALL have port seg_txt, output, 7 bits: segment pattern, bit order gfedcba, active high.
REQ-016 SHALL have port seg_com, output, 8 bits: digit select, active low; digit0 = 8'b0111_1111, digit1 = 8'b1011_1111.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_KEY, CHECK, DONE.
REQ-018 In IDLE, start SHALL clear the board, set turn_o=0 and result_o=00, and move the FSM to WAIT_KEY on the next cycle.
REQ-019 start in any state SHALL restart the game exactly as REQ-018; start SHALL have priority over a key_valid in the same cycle.
REQ-020 In WAIT_KEY, key_valid at cycle t with key_idx<N*N and the cell empty SHALL write the mover's mark at t+1, pulse move_ack at t+1, and enter CHECK with busy=1.
REQ-021 In WAIT_KEY, key_valid at cycle t with key_idx>=N*N or the cell occupied SHALL pulse move_err at t+1 and change nothing else.
REQ-022 key_valid in IDLE, CHECK or DONE SHALL be ignored: no ack, no err, no board change.
REQ-023 CHECK SHALL take exactly 4 cycles (t+1..t+4), one per direction: row, column, diagonal, anti-diagonal.
REQ-024 Each CHECK cycle SHALL count contiguous same-mark cells through the placed cell in both senses, clipped at the board edges; a count of K or more SHALL register a win.
REQ-025 At t+5, on a win, result_o SHALL be 01 (X) or 10 (O) and the FSM SHALL enter DONE.
REQ-026 At t+5, with no win and all N*N cells filled, result_o SHALL be 11 and the FSM SHALL enter DONE; a win on the last move SHALL take priority over the draw.
REQ-027 At t+5, otherwise, turn_o SHALL toggle and the FSM SHALL return to WAIT_KEY; busy SHALL be 0 from t+5.
REQ-028 A move counter of $clog2(N*N+1) bits SHALL count placed marks; it SHALL be cleared by start and by reset.
REQ-029 In DONE, board_o, turn_o and result_o SHALL hold until start or reset.
REQ-030 The scan counter SHALL wrap at DIV-1 and advance the digit 0 -> 1 -> 0.
REQ-031 While in WAIT_KEY or CHECK, the display SHALL show "P1" when turn_o=0 and "P2" when turn_o=1.
REQ-032 In DONE with a win, the display SHALL show the winner's "P1" or "P2", blinking with a period of 512*DIV cycles (on for 256*DIV, off for 256*DIV); while off, seg_com SHALL be 8'hFF.
REQ-033 In DONE with a draw, the display SHALL show "dr" steadily; in IDLE it SHALL show "--".

Reset
REQ-034 With rst_n=0 at a clock edge, the block SHALL enter IDLE with board_o=0, turn_o=0, result_o=00, move_ack=0, move_err=0, busy=0, scan counter=0, digit=0, seg_com=8'hFF and seg_txt=0.
REQ-035 Reset during CHECK SHALL discard the evaluation in progress; no result or turn update SHALL follow.

Structure
REQ-036 Package game_pkg SHALL hold the cell codes, the result codes, the FSM state enum and the glyph constants for P, 1, 2, d, r and -.
REQ-037 The display multiplexing and blink logic SHALL live in a sub-module seg_scan, parameterised by DIV.
REQ-038 The line counting SHALL be combinational, indexed by a 2-bit direction register; no full-board scan SHALL be used.

Verification
REQ-039 Reset then start: result_o=00, turn_o=0, board_o=0; after DIV cycles, seg_com=8'b0111_1111 and seg_txt=P.
REQ-040 N=3, keys 0,3,1,4,2: result_o=01 five cycles after the key-2 strobe, FSM in DONE; a later key 8 produces no ack and no board change.
REQ-041 N=3, X plays 4, then key 4 again: move_err at t+1, board unchanged, turn_o stays 1; then key 9: move_err.
REQ-042 N=3, keys 0,1,2,4,3,5,7,6,8: result_o=11, display "dr".
REQ-043 N=3, keys 0,1,2,4,3,5,7,8,6: result_o=01, not 11 (win on the last move).
REQ-044 N=4, K=3, keys 1,0,6,4,11: diagonal win, result_o=01; a separate run asserts rst_n=0 at t+2 of a CHECK and sees IDLE with board_o=0 and no result update.
